// File: rtl/mips_defs_pkg.sv
// Shared fetch-path definitions: data widths, default reset PC, fetch FSM states
// and the queue entry layout.
package mips_defs;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WAIT_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched instructions; flush has priority over push/pop,
// and push into a full queue is accepted only alongside a pop.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read, results queued for decode.
// Optional stall counter port enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc4,
    input  logic               decode_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target_pc;
    logic [CW-1:0]     q_count;
    logic [SW-1:0]     slots_used;
    logic              q_full;
    logic              q_empty;
    logic              outstanding;
    logic              ack_live;
    logic              push;
    logic              pop;
    fetch_entry_t      q_in;
    fetch_entry_t      q_head;

    // imem_req is combinational so a request can go out in the first cycle
    // after reset and be acknowledged in that same cycle.
    assign outstanding = (state != ST_IDLE);
    assign slots_used  = SW'(q_count) + SW'(outstanding);
    assign imem_req    = !reset && (outstanding || (slots_used < SW'(QDEPTH)));
    assign imem_addr   = outstanding ? req_addr : fetch_pc;
    assign target_pc   = redirect_pc & ~32'h3;

    assign ack_live = imem_req && imem_ack;
    assign push     = ack_live && (state != ST_WAIT_DROP) && !redirect && (!q_full || pop);
    assign pop      = if_valid && decode_ready && !redirect;
    assign q_in     = '{instr: imem_rdata, pc: imem_addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            if (imem_req && !imem_ack) begin
                state    <= ST_WAIT_DROP;
                req_addr <= imem_addr;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end else begin
                            state    <= ST_WAIT;
                            req_addr <= fetch_pc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= ST_IDLE;
                    end
                end
                ST_WAIT_DROP: begin
                    if (imem_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(QDEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (q_in),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign if_valid = !q_empty;
    assign if_instr = q_head.instr;
    assign if_pc    = q_head.pc;
    assign if_pc4   = q_head.pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (if_valid && !decode_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, reset/stall sequences, and a
// randomized run checked against a program-order model of the fetch stream.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        decode_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .decode_ready(decode_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Memory image: an odd multiplier keeps words distinct per address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic drive(input logic ack, input logic dr, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        decode_ready = dr;
        redirect     = rd;
        redirect_pc  = rpc;
        imem_ack     = ack;
        imem_rdata   = ack ? word_at(imem_addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; decode_ready = 1'b0;
        @(negedge clk);
        #1;
        check("reset_req", {31'd0, imem_req}, 32'd0);
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ack;
        logic        dr;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vt [20];

    logic        pending, prev_wait, hold_prev, accept;
    int          wait_left, accepts;
    logic [31:0] exp_pc, prev_addr, prev_pc, prev_instr;

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        decode_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        //          ack  dr   rd   rpc            req  chk  addr           vld  pc
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h4};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h8};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h8};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h8};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h8};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h8};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h8};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b1, 32'hC};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b1, 32'h10};
        vt[11] = '{1'b0, 1'b1, 1'b1, 32'h103,      1'b1, 1'b1, 32'h14,       1'b0, 32'h0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b0, 32'h0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b0, 32'h0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b0, 32'h0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b1, 32'h100};
        vt[16] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100};
        vt[17] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vt[18] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC};
        vt[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0};

        do_reset();

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].ack, vt[i].dr, vt[i].rd, vt[i].rpc);
            check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
            if (vt[i].chk_addr) check($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
            check($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vt[i].valid});
            if (vt[i].valid) begin
                check($sformatf("vec%0d_pc", i), if_pc, vt[i].pc);
                check($sformatf("vec%0d_pc4", i), if_pc4, vt[i].pc + 32'd4);
                check($sformatf("vec%0d_instr", i), if_instr, word_at(vt[i].pc));
            end
        end

        // Reset arriving while a request is outstanding and acked that cycle.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("mid_req_first", {imem_req, imem_addr[30:0]}, 32'h8000_0000);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = word_at(32'h0);
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        check("mid_req_reissue", {imem_req, imem_addr[30:0]}, 32'h8000_0000);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("mid_req_nopush", {31'd0, if_valid}, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        check("stall_cnt_reset", stall_cnt, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_cnt_7", stall_cnt, 32'd7);
        do_reset();
        #1;
        check("stall_cnt_cleared", stall_cnt, 32'd0);
`endif

        // Randomized run: the consumed stream must follow program order from
        // the latest redirect target, with words matching the memory image.
        do_reset();
        exp_pc = 32'h0; pending = 1'b0; wait_left = 0; accepts = 0;
        prev_wait = 1'b0; hold_prev = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_instr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            decode_ready = ($urandom_range(0, 3) != 0);
            redirect     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = $urandom;
            if (imem_req) begin
                if (!pending) begin
                    pending   = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    pending    = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                pending    = 1'b0;
            end
            #1;
            if (imem_req) check("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (prev_wait) begin
                check("rnd_req_held", {31'd0, imem_req}, 32'd1);
                check("rnd_addr_held", imem_addr, prev_addr);
            end
            if (hold_prev) begin
                check("rnd_head_valid", {31'd0, if_valid}, 32'd1);
                check("rnd_head_pc", if_pc, prev_pc);
                check("rnd_head_instr", if_instr, prev_instr);
            end
            if (if_valid) check("rnd_instr", if_instr, word_at(if_pc));
            accept = if_valid && decode_ready && !redirect;
            if (accept) begin
                check("rnd_order_pc", if_pc, exp_pc);
                check("rnd_pc4", if_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'h3;
            prev_wait  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            hold_prev  = if_valid && !decode_ready && !redirect;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
        n_checks++;
        if (accepts < 200) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d accepted instructions expected at least 200", accepts);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
